// File: rtl/project_pkg.sv
// project_pkg: constants and types shared by the matrix input path.
// The storage block and the display block read the dimension limits from here,
// so all of them agree on MAX_DIM and ELEM_MAX.
package project_pkg;

  localparam int MAX_DIM  = 5;  // maximum rows and maximum columns
  localparam int ELEM_MAX = 9;  // largest legal (unsigned) element value
  localparam int DATA_W   = 8;  // parsed number / element width
  localparam int ADDR_W   = 5;  // storage address width, 2**ADDR_W >= MAX_DIM*MAX_DIM

  // matrix_input_ctrl capture states
  typedef enum logic [2:0] {
    IN_IDLE     = 3'd0,
    IN_GET_ROWS = 3'd1,
    IN_GET_COLS = 3'd2,
    IN_GET_ELEM = 3'd3,
    IN_PAD      = 3'd4,
    IN_DONE     = 3'd5
  } input_state_t;

endpackage

// File: rtl/matrix_input_ctrl_rc_counter.sv
// mat_rc_counter: row/column position counter for a row-major matrix walk.
//   clk, rst_n          clock, asynchronous active-low reset
//   clr                 return to (0,0)
//   adv                 step to the next element; col wraps at mat_cols, then row++
//   mat_rows, mat_cols  captured matrix dimensions
//   last                current position is (mat_rows-1, mat_cols-1)
//   addr                storage address of the current position, row*MAX_DIM+col
module mat_rc_counter #(
  parameter int MAX_DIM = project_pkg::MAX_DIM,
  parameter int ADDR_W  = project_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              adv,
  input  logic [2:0]        mat_rows,
  input  logic [2:0]        mat_cols,
  output logic              last,
  output logic [ADDR_W-1:0] addr
);

  logic [2:0] row;
  logic [2:0] col;
  logic       col_last;

  assign col_last = (col == mat_cols - 3'd1);
  assign last     = col_last && (row == mat_rows - 3'd1);
  // Storage is laid out with a fixed MAX_DIM row pitch, so unused columns are skipped.
  assign addr     = ADDR_W'(row) * ADDR_W'(MAX_DIM) + ADDR_W'(col);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (adv) begin
      if (col_last) begin
        col <= '0;
        row <= row + 3'd1;
      end else begin
        col <= col + 3'd1;
      end
    end
  end

endmodule

// File: rtl/matrix_input_ctrl.sv
// matrix_input_ctrl: captures one matrix (rows, cols, elements) from the parsed
// number stream and writes it row-major into matrix storage.
//   clk, rst_n   clock, asynchronous active-low reset
//   start        pulse: begin (or restart) a capture
//   abort        level: return to IDLE immediately, cancelling any pending write
//   num_valid    strobe: num_data holds a parsed number
//   num_data     parsed unsigned number
//   num_end      strobe: end-of-matrix terminator
//   wr_en/wr_addr/wr_data   storage write, one cycle after the element is accepted
//   mat_rows, mat_cols      captured dimensions, held until the next start
//   busy         high whenever the capture FSM is not IDLE
//   err_flag     sticky: out-of-range dimension/element or early terminator seen
//   input_done   one-cycle pulse the cycle after the final write
//   state_dbg    current capture state
//
// Interface semantics: num_valid and num_end are single-cycle strobes with no
// back-pressure; each one is consumed on the rising edge where it is high, or
// dropped if the current state does not use it. wr_en is a single-cycle write
// strobe qualified by wr_addr/wr_data in the same cycle; storage cannot stall it.
module matrix_input_ctrl #(
  parameter int MAX_DIM  = project_pkg::MAX_DIM,
  parameter int ELEM_MAX = project_pkg::ELEM_MAX,
  parameter int DATA_W   = project_pkg::DATA_W,
  parameter int ADDR_W   = project_pkg::ADDR_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      num_valid,
  input  logic [DATA_W-1:0]         num_data,
  input  logic                      num_end,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [DATA_W-1:0]         wr_data,
  output logic [2:0]                mat_rows,
  output logic [2:0]                mat_cols,
  output logic                      busy,
  output logic                      err_flag,
  output logic                      input_done,
  output project_pkg::input_state_t state_dbg
);

  import project_pkg::*;

  input_state_t      state, state_nxt;
  logic              cnt_clr, cnt_adv, cnt_last;
  logic [ADDR_W-1:0] cnt_addr;
  logic              wr_nxt;
  logic [DATA_W-1:0] wr_data_nxt;
  logic              err_set, err_clr;
  logic              rows_ld, cols_ld, dims_clr;
  logic              done_nxt;
  logic              dim_ok, elem_ok;

  assign dim_ok  = (num_data >= DATA_W'(1)) && (num_data <= DATA_W'(MAX_DIM));
  assign elem_ok = (num_data <= DATA_W'(ELEM_MAX));

  mat_rc_counter #(
    .MAX_DIM (MAX_DIM),
    .ADDR_W  (ADDR_W)
  ) u_rc (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr),
    .adv      (cnt_adv),
    .mat_rows (mat_rows),
    .mat_cols (mat_cols),
    .last     (cnt_last),
    .addr     (cnt_addr)
  );

  always_comb begin
    state_nxt   = state;
    cnt_clr     = 1'b0;
    cnt_adv     = 1'b0;
    wr_nxt      = 1'b0;
    wr_data_nxt = '0;
    err_set     = 1'b0;
    err_clr     = 1'b0;
    rows_ld     = 1'b0;
    cols_ld     = 1'b0;
    dims_clr    = 1'b0;
    done_nxt    = 1'b0;

    if (abort) begin
      // No write or done pulse is scheduled; err_flag keeps its value.
      state_nxt = IN_IDLE;
    end else if (start) begin
      state_nxt = IN_GET_ROWS;
      cnt_clr   = 1'b1;
      err_clr   = 1'b1;
      dims_clr  = 1'b1;
    end else begin
      unique case (state)
        IN_IDLE: ;
        IN_GET_ROWS: begin
          if (num_valid) begin
            if (dim_ok) begin
              rows_ld   = 1'b1;
              state_nxt = IN_GET_COLS;
            end else begin
              err_set = 1'b1;
            end
          end
          if (num_end) err_set = 1'b1;
        end
        IN_GET_COLS: begin
          if (num_valid) begin
            if (dim_ok) begin
              cols_ld   = 1'b1;
              state_nxt = IN_GET_ELEM;
            end else begin
              err_set = 1'b1;
            end
          end
          if (num_end) err_set = 1'b1;
        end
        IN_GET_ELEM: begin
          if (num_valid && elem_ok) begin
            wr_nxt      = 1'b1;
            wr_data_nxt = num_data;
            cnt_adv     = 1'b1;
            // A simultaneous terminator applies after this element is taken.
            if (cnt_last)     state_nxt = IN_DONE;
            else if (num_end) state_nxt = IN_PAD;
          end else begin
            if (num_valid) err_set = 1'b1;
            if (num_end) state_nxt = IN_PAD;
          end
        end
        IN_PAD: begin
          wr_nxt  = 1'b1;
          cnt_adv = 1'b1;
          if (cnt_last) state_nxt = IN_DONE;
        end
        IN_DONE: begin
          // Entered on the edge that scheduled the final write, so the
          // registered pulse lands the cycle after that write.
          done_nxt  = 1'b1;
          state_nxt = IN_IDLE;
        end
        default: state_nxt = IN_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IN_IDLE;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      mat_rows   <= '0;
      mat_cols   <= '0;
      err_flag   <= 1'b0;
      input_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      wr_en      <= wr_nxt;
      input_done <= done_nxt;
      if (wr_nxt) begin
        wr_addr <= cnt_addr;
        wr_data <= wr_data_nxt;
      end
      if (dims_clr) begin
        mat_rows <= '0;
        mat_cols <= '0;
      end
      if (rows_ld) mat_rows <= num_data[2:0];
      if (cols_ld) mat_cols <= num_data[2:0];
      if (err_clr)      err_flag <= 1'b0;
      else if (err_set) err_flag <= 1'b1;
    end
  end

  assign busy      = (state != IN_IDLE);
  assign state_dbg = state;

endmodule
